// File: rtl/mac_tap_sequencer.sv
// mac_tap_sequencer: streams coefficient/sample pairs into a MAC so that it computes a TAPS-tap FIR output per sample
module mac_tap_sequencer #(
  parameter int WIDTH    = 16,
  parameter int TAPS     = 8,
  parameter int TAP_BITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coef_we,
  input  logic [TAP_BITS-1:0] coef_addr,
  input  logic [WIDTH-1:0]    coef_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [WIDTH-1:0]    s_data,
  output logic                mac_clr,
  output logic                mac_ena,
  output logic [WIDTH-1:0]    mac_k,
  output logic [WIDTH-1:0]    mac_x,
  output logic                acc_valid,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  localparam logic [TAP_BITS-1:0] LAST = TAP_BITS'(TAPS - 1);
  state_t              state_q, state_d;
  logic [TAP_BITS-1:0] tap_q, tap_d;
  logic [WIDTH-1:0]    delay_q [TAPS];
  logic [WIDTH-1:0]    delay_d [TAPS];
  logic [WIDTH-1:0]    coef_q [TAPS];
  logic [WIDTH-1:0]    coef_d [TAPS];
  logic                s_ready_q, s_ready_d;
  logic                mac_clr_q, mac_clr_d;
  logic                mac_ena_q, mac_ena_d;
  logic                acc_valid_q, acc_valid_d;
  logic                busy_q, busy_d;
  logic [WIDTH-1:0]    mac_k_q, mac_k_d;
  logic [WIDTH-1:0]    mac_x_q, mac_x_d;
  logic                accept;
  assign accept    = s_valid && s_ready_q;
  assign s_ready   = s_ready_q;
  assign mac_clr   = mac_clr_q;
  assign mac_ena   = mac_ena_q;
  assign acc_valid = acc_valid_q;
  assign busy      = busy_q;
  assign mac_k     = mac_k_q;
  assign mac_x     = mac_x_q;
  // state, tap counter, delay line and coefficient bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tap_q   <= '0;
      for (int i = 0; i < TAPS; i++) begin
        delay_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      delay_q <= delay_d;
      coef_q  <= coef_d;
    end
  end
  // FSM next state: one clear cycle, TAPS run cycles, one done cycle per sample
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    case (state_q)
      IDLE:    state_d = accept ? CLEAR : IDLE;
      CLEAR: begin
        state_d = RUN;
        tap_d   = '0;
      end
      RUN: begin
        state_d = (tap_q == LAST) ? DONE : RUN;
        tap_d   = (tap_q == LAST) ? tap_q : tap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // shift on acceptance; coefficient writes only land while idle, so a dot product never sees a change
  always_comb begin
    delay_d[0] = accept ? s_data : delay_q[0];
    for (int i = 1; i < TAPS; i++)
      delay_d[i] = accept ? delay_q[i-1] : delay_q[i];
    for (int i = 0; i < TAPS; i++)
      coef_d[i] = (coef_we && state_q == IDLE && coef_addr == TAP_BITS'(i)) ? coef_data : coef_q[i];
  end
  // outputs decoded from the next state so they are registered and line up with the state they describe
  always_comb begin
    s_ready_d   = state_d == IDLE;
    mac_clr_d   = state_d == CLEAR;
    mac_ena_d   = state_d == RUN;
    acc_valid_d = state_d == DONE;
    busy_d      = state_d != IDLE;
    mac_k_d     = mac_ena_d ? coef_q[tap_d] : mac_k_q;
    mac_x_d     = mac_ena_d ? delay_q[tap_d] : mac_x_q;
  end
  // output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_ready_q   <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_ena_q   <= 1'b0;
      acc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mac_k_q     <= '0;
      mac_x_q     <= '0;
    end else begin
      s_ready_q   <= s_ready_d;
      mac_clr_q   <= mac_clr_d;
      mac_ena_q   <= mac_ena_d;
      acc_valid_q <= acc_valid_d;
      busy_q      <= busy_d;
      mac_k_q     <= mac_k_d;
      mac_x_q     <= mac_x_d;
    end
  end
endmodule

// File: tb/tb_mac_tap_sequencer.sv
// tb_mac_tap_sequencer: directed and randomized checks of the FIR tap sequencer against a cycle-phase reference model
module tb_mac_tap_sequencer;
  localparam int W  = 16;
  localparam int T  = 8;
  localparam int TB = 3;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          coef_we = 1'b0;
  logic [TB-1:0] coef_addr = '0;
  logic [W-1:0]  coef_data = '0;
  logic          s_valid = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_ready, mac_clr, mac_ena, acc_valid, busy;
  logic [W-1:0]  mac_k, mac_x;
  logic [2*W-1:0] acc_out;
  int n_cmp = 0;
  int n_err = 0;
  int ph = 0;
  bit rdy = 0;
  bit acc_now = 0;
  logic [W-1:0]   mc [T];
  logic [W-1:0]   md [T];
  logic [W-1:0]   ek = '0;
  logic [W-1:0]   ex = '0;
  logic [2*W-1:0] edot = '0;
  logic [2*W-1:0] acc_r;
  logic [W-1:0]   k2, x2;
  mac_tap_sequencer #(.WIDTH(W), .TAPS(T), .TAP_BITS(TB)) dut (
    .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .mac_clr(mac_clr), .mac_ena(mac_ena),
    .mac_k(mac_k), .mac_x(mac_x), .acc_valid(acc_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  // downstream MAC cell: clear, then accumulate k*x on enable
  always_ff @(posedge clk or posedge reset)
    if (reset) acc_out <= '0;
    else if (mac_clr) acc_out <= '0;
    else if (mac_ena) acc_out <= acc_out + mac_k * mac_x;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic mclear();
    ph = 0; rdy = 0; ek = '0; ex = '0;
    for (int i = 0; i < T; i++) begin mc[i] = '0; md[i] = '0; end
  endtask
  task automatic chk_all();
    chk("s_ready", 32'(s_ready), 32'(rdy));
    chk("mac_clr", 32'(mac_clr), 32'(ph == 1));
    chk("mac_ena", 32'(mac_ena), 32'(ph >= 2 && ph <= T + 1));
    chk("acc_valid", 32'(acc_valid), 32'(ph == T + 2));
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("mac_k", 32'(mac_k), 32'(ek));
    chk("mac_x", 32'(mac_x), 32'(ex));
    if (ph == T + 2) chk("acc_out", acc_out, edot);
  endtask
  // one clock: advance the reference model by the sequencer's timing rules, then compare
  task automatic step();
    @(posedge clk);
    acc_now = 0;
    if (ph == 0 && coef_we) mc[coef_addr] = coef_data;
    if (ph == 0 && !rdy) rdy = 1;
    else if (rdy) begin
      if (s_valid) begin
        for (int i = T - 1; i > 0; i--) md[i] = md[i-1];
        md[0] = s_data;
        edot = '0;
        for (int i = 0; i < T; i++) edot += 32'(mc[i]) * 32'(md[i]);
        ph = 1; rdy = 0; acc_now = 1;
      end
    end else begin
      ph++;
      if (ph == T + 3) begin ph = 0; rdy = 1; end
    end
    if (ph >= 2 && ph <= T + 1) begin ek = mc[ph-2]; ex = md[ph-2]; end
    #1;
    chk_all();
  endtask
  task automatic do_reset(input int cyc);
    reset = 1'b1;
    mclear();
    #1;
    chk_all();
    repeat (cyc) begin @(posedge clk); #1; chk_all(); end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic wcoef(input logic [TB-1:0] a, input logic [W-1:0] d);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    step();
    coef_we = 1'b0;
  endtask
  // wr: 0 = coefficient write alongside the sample, 1..T+2 = write while busy, else none
  task automatic send(input logic [W-1:0] x, input int wr, input logic [TB-1:0] wa, input logic [W-1:0] wd,
                      output logic [31:0] acc, output logic [W-1:0] k, output logic [W-1:0] xo);
    int n, lo, lat;
    s_valid = 1'b1; s_data = x;
    if (wr == 0) begin coef_we = 1'b1; coef_addr = wa; coef_data = wd; end
    n = 0;
    acc_now = 0;
    while (!acc_now && n < 40) begin step(); n++; end
    s_valid = 1'b0; coef_we = 1'b0;
    chk("accept_timeout", 32'(acc_now), 32'd1);
    lo = (s_ready === 1'b0) ? 1 : 0;
    lat = 0; acc = '0; k = '0; xo = '0;
    for (int c = 2; c <= T + 3; c++) begin
      if (wr == c - 1) begin coef_we = 1'b1; coef_addr = wa; coef_data = wd; end
      step();
      coef_we = 1'b0;
      if (c == 2) begin k = mac_k; xo = mac_x; end
      if (acc_valid === 1'b1) begin acc = acc_out; lat = c; end
      if (s_ready === 1'b0) lo++;
    end
    chk("latency", 32'(lat), 32'(T + 2));
    chk("ready_low", 32'(lo), 32'(T + 2));
  endtask
  initial begin
    mclear();
    do_reset(2);
    repeat (4) step();
    for (int i = 0; i < T; i++) wcoef(TB'(i), 16'd5);
    for (int n = 0; n < T; n++) begin
      send(16'd1, -1, '0, '0, acc_r, k2, x2);
      chk("const_acc", acc_r, 32'(5 * (n + 1)));
    end
    for (int i = 0; i < T; i++) wcoef(TB'(i), W'(i + 1));
    for (int n = 0; n < T; n++) send(16'd0, -1, '0, '0, acc_r, k2, x2);
    send(16'd1, -1, '0, '0, acc_r, k2, x2);
    chk("impulse_acc", acc_r, 32'd1);
    chk("impulse_k0", 32'(k2), 32'd1);
    for (int j = 1; j <= T; j++) begin
      send(16'd0, -1, '0, '0, acc_r, k2, x2);
      chk("impulse_acc", acc_r, (j < T) ? 32'(j + 1) : 32'd0);
    end
    send(16'd3, 6, '0, 16'd99, acc_r, k2, x2);
    chk("busy_wr_cur", acc_r, 32'd3);
    send(16'd2, -1, '0, '0, acc_r, k2, x2);
    chk("busy_wr_next", acc_r, 32'd8);
    s_valid = 1'b1; s_data = 16'd1;
    acc_now = 0;
    for (int n = 0; n < 40 && !acc_now; n++) step();
    s_valid = 1'b0;
    repeat (5) step();
    chk("tap4_ena", 32'(mac_ena), 32'd1);
    do_reset(2);
    send(16'd1, -1, '0, '0, acc_r, k2, x2);
    chk("coef_cleared", acc_r, 32'd0);
    do_reset(2);
    for (int i = 0; i < T; i++) wcoef(TB'(i), 16'd5);
    send(16'd1, -1, '0, '0, acc_r, k2, x2);
    chk("delay_cleared", acc_r, 32'd5);
    wcoef('0, 16'hFFFF);
    for (int i = 1; i < T; i++) wcoef(TB'(i), 16'd0);
    send(16'hFFFF, -1, '0, '0, acc_r, k2, x2);
    chk("max_acc", acc_r, 32'hFFFE0001);
    chk("max_k", 32'(k2), 32'hFFFF);
    chk("max_x", 32'(x2), 32'hFFFF);
    for (int r = 0; r < 40; r++) begin
      int wr;
      repeat ($urandom_range(0, 2)) wcoef(TB'($urandom_range(0, T - 1)), W'($urandom));
      wr = $urandom_range(0, T + 3);
      send(W'($urandom), (wr == T + 3) ? -1 : wr, TB'($urandom_range(0, T - 1)), W'($urandom), acc_r, k2, x2);
      repeat ($urandom_range(0, 3)) step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
